// File: rtl/bp_be_stride_detector.sv
// Stride detector: trains a small PC-indexed stride table from committed loads and
// issues striding-load descriptors. Optional stats counters: BP_BE_STRIDE_DETECT_STATS_EN.
module bp_be_stride_detector #(
  parameter int vaddr_width_p    = 39,
  parameter int entries_p        = 4,
  parameter int conf_thresh_p    = 2,
  parameter int stride_width_p   = 8,
  parameter int loop_range_p     = 8,
  parameter int prefetch_depth_p = 8
) (
  input  logic                      clk_i,
  input  logic                      reset_n_i,
  input  logic                      flush_i,
  input  logic                      load_v_i,
  input  logic [vaddr_width_p-1:0]  load_pc_i,
  input  logic [vaddr_width_p-1:0]  load_eff_addr_i,
  output logic                      v_o,
  input  logic                      ready_and_i,
  output logic [vaddr_width_p-1:0]  pc_o,
  output logic [vaddr_width_p-1:0]  eff_addr_o,
  output logic [stride_width_p-1:0] stride_o,
  output logic [loop_range_p-1:0]   loop_counter_o
`ifdef BP_BE_STRIDE_DETECT_STATS_EN
  , output logic [15:0]             trigger_count_o
  , output logic [15:0]             drop_count_o
`endif
);

  localparam int idx_w  = (entries_p > 1) ? $clog2(entries_p) : 1;
  localparam int conf_w = $clog2(conf_thresh_p + 1);
  localparam logic [conf_w-1:0] thresh   = conf_w'(conf_thresh_p);
  localparam logic [idx_w-1:0]  last_idx = idx_w'(entries_p - 1);

  logic [entries_p-1:0]      valid_r;
  logic [entries_p-1:0]      issued_r;
  logic [vaddr_width_p-1:0]  tag_r    [entries_p];
  logic [vaddr_width_p-1:0]  last_r   [entries_p];
  logic [stride_width_p-1:0] stride_r [entries_p];
  logic [conf_w-1:0]         conf_r   [entries_p];
  logic [idx_w-1:0]          rr_r;

  logic                      hit, has_free;
  logic [idx_w-1:0]          hit_idx, free_idx, alloc_idx;
  logic [vaddr_width_p-1:0]  delta;
  logic                      in_range, match, trigger, out_free, accept;
  logic [conf_w-1:0]         conf_inc;

  always_comb begin
    hit      = 1'b0;
    hit_idx  = '0;
    has_free = 1'b0;
    free_idx = '0;
    for (int unsigned i = 0; i < entries_p; i++) begin
      if (!hit && valid_r[i] && tag_r[i] == load_pc_i) begin
        hit     = 1'b1;
        hit_idx = idx_w'(i);
      end
      if (!has_free && !valid_r[i]) begin
        has_free = 1'b1;
        free_idx = idx_w'(i);
      end
    end
  end

  // Saturated conf is compared against the threshold so a dropped trigger
  // is retried by the next matching load (issued stays clear).
  always_comb begin
    alloc_idx = has_free ? free_idx : rr_r;
    delta     = load_eff_addr_i - last_r[hit_idx];
    in_range  = (delta != '0) && (delta[vaddr_width_p-1:stride_width_p] == '0);
    match     = hit && in_range && (delta[stride_width_p-1:0] == stride_r[hit_idx]);
    conf_inc  = (conf_r[hit_idx] >= thresh - 1'b1) ? thresh : conf_r[hit_idx] + 1'b1;
    trigger   = load_v_i && !flush_i && match && (conf_inc == thresh) && !issued_r[hit_idx];
    out_free  = !v_o || ready_and_i;
    accept    = trigger && out_free;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      valid_r  <= '0;
      issued_r <= '0;
      rr_r     <= '0;
      for (int unsigned i = 0; i < entries_p; i++) begin
        tag_r[i]    <= '0;
        last_r[i]   <= '0;
        stride_r[i] <= '0;
        conf_r[i]   <= '0;
      end
    end else if (flush_i) begin
      valid_r <= '0;
    end else if (load_v_i) begin
      if (!hit) begin
        valid_r[alloc_idx]  <= 1'b1;
        issued_r[alloc_idx] <= 1'b0;
        tag_r[alloc_idx]    <= load_pc_i;
        last_r[alloc_idx]   <= load_eff_addr_i;
        stride_r[alloc_idx] <= '0;
        conf_r[alloc_idx]   <= '0;
        if (!has_free) rr_r <= (rr_r == last_idx) ? '0 : rr_r + 1'b1;
      end else begin
        last_r[hit_idx] <= load_eff_addr_i;
        if (!match) begin
          stride_r[hit_idx] <= in_range ? delta[stride_width_p-1:0] : '0;
          conf_r[hit_idx]   <= '0;
          issued_r[hit_idx] <= 1'b0;
        end else begin
          conf_r[hit_idx] <= conf_inc;
          if (accept) issued_r[hit_idx] <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      v_o            <= 1'b0;
      pc_o           <= '0;
      eff_addr_o     <= '0;
      stride_o       <= '0;
      loop_counter_o <= '0;
    end else if (flush_i) begin
      v_o <= 1'b0;
    end else if (accept) begin
      v_o            <= 1'b1;
      pc_o           <= load_pc_i;
      eff_addr_o     <= load_eff_addr_i;
      stride_o       <= delta[stride_width_p-1:0];
      loop_counter_o <= loop_range_p'(prefetch_depth_p);
    end else if (ready_and_i) begin
      v_o <= 1'b0;
    end
  end

`ifdef BP_BE_STRIDE_DETECT_STATS_EN
  logic drop;
  assign drop = trigger && !out_free;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      trigger_count_o <= '0;
      drop_count_o    <= '0;
    end else if (flush_i) begin
      trigger_count_o <= '0;
      drop_count_o    <= '0;
    end else begin
      if (accept && trigger_count_o != '1) trigger_count_o <= trigger_count_o + 16'd1;
      if (drop && drop_count_o != '1)      drop_count_o    <= drop_count_o + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_bp_be_stride_detector.sv
// Self-checking bench for bp_be_stride_detector: directed vector table, hand-written
// corner sequences, and randomized traffic against a transaction-level model.
module tb_bp_be_stride_detector;

  localparam int VW = 39;
  localparam logic [63:0] MASK = (64'd1 << VW) - 64'd1;
  localparam logic [VW-1:0] PA = 39'h80000100;

  logic          clk_i = 1'b0;
  logic          reset_n_i = 1'b0;
  logic          flush_i = 1'b0;
  logic          load_v_i = 1'b0;
  logic [VW-1:0] load_pc_i = '0;
  logic [VW-1:0] load_eff_addr_i = '0;
  logic          ready_and_i = 1'b0;
  logic          v_o;
  logic [VW-1:0] pc_o, eff_addr_o;
  logic [7:0]    stride_o, loop_counter_o;

  int total = 0;
  int bad   = 0;

  bp_be_stride_detector #(.vaddr_width_p(VW), .entries_p(4), .conf_thresh_p(2),
                          .stride_width_p(8), .loop_range_p(8), .prefetch_depth_p(8)) dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i), .flush_i(flush_i), .load_v_i(load_v_i),
    .load_pc_i(load_pc_i), .load_eff_addr_i(load_eff_addr_i), .v_o(v_o),
    .ready_and_i(ready_and_i), .pc_o(pc_o), .eff_addr_o(eff_addr_o),
    .stride_o(stride_o), .loop_counter_o(loop_counter_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cyc(input bit fl, input bit lv, input logic [VW-1:0] pc,
                     input logic [VW-1:0] addr, input bit rdy);
    flush_i = fl; load_v_i = lv; load_pc_i = pc; load_eff_addr_i = addr; ready_and_i = rdy;
    @(posedge clk_i); #1;
  endtask

  task automatic ld(input logic [VW-1:0] pc, input logic [VW-1:0] addr, input bit rdy);
    cyc(1'b0, 1'b1, pc, addr, rdy);
  endtask

  task automatic do_reset();
    reset_n_i = 1'b0; flush_i = 1'b0; load_v_i = 1'b0; ready_and_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
    chk("reset_v", 64'(v_o), 64'd0);
    chk("reset_addr", 64'(eff_addr_o), 64'd0);
    chk("reset_pc", 64'(pc_o), 64'd0);
    chk("reset_stride", 64'(stride_o), 64'd0);
    chk("reset_lc", 64'(loop_counter_o), 64'd0);
    reset_n_i = 1'b1;
  endtask

  // Transaction-level reference: table of trained streams plus one descriptor slot.
  typedef struct {
    bit valid; longint pc; longint last; longint stride; int conf; bit issued;
  } ment_t;
  ment_t  mt[4];
  int     m_rr;
  bit     m_v;
  longint m_pc, m_addr, m_stride, m_lc;

  function automatic void model_reset();
    for (int i = 0; i < 4; i++) mt[i] = '{1'b0, 0, 0, 0, 0, 1'b0};
    m_rr = 0; m_v = 0; m_pc = 0; m_addr = 0; m_stride = 0; m_lc = 0;
  endfunction

  function automatic void model_step(bit fl, bit lv, longint pc, longint addr, bit rdy);
    bit     free_out = !m_v || rdy;
    int     h = -1;
    int     f = -1;
    longint d;
    bit     inr, m, trig;
    int     nc;
    if (fl) begin
      for (int i = 0; i < 4; i++) mt[i].valid = 0;
      m_v = 0;
      return;
    end
    if (m_v && rdy) m_v = 0;
    if (!lv) return;
    for (int i = 0; i < 4; i++) if (h < 0 && mt[i].valid && mt[i].pc == pc) h = i;
    if (h < 0) begin
      for (int i = 0; i < 4; i++) if (f < 0 && !mt[i].valid) f = i;
      if (f < 0) begin f = m_rr; m_rr = (m_rr + 1) % 4; end
      mt[f] = '{1'b1, pc, addr, 0, 0, 1'b0};
      return;
    end
    d   = (addr - mt[h].last) & longint'(MASK);
    inr = (d >= 1) && (d <= 255);
    m   = inr && (d == mt[h].stride);
    mt[h].last = addr;
    if (!m) begin
      mt[h].stride = inr ? d : 0;
      mt[h].conf = 0;
      mt[h].issued = 0;
    end else begin
      nc   = (mt[h].conf + 1 > 2) ? 2 : mt[h].conf + 1;
      trig = (nc == 2) && !mt[h].issued;
      mt[h].conf = nc;
      if (trig && free_out) begin
        mt[h].issued = 1;
        m_v = 1; m_pc = pc; m_addr = addr; m_stride = d; m_lc = 8;
      end
    end
  endfunction

  typedef struct {
    bit fl; bit lv; logic [VW-1:0] addr; bit rdy;
    bit ev; logic [VW-1:0] eaddr; logic [7:0] estride;
  } vec_t;
  vec_t tbl[16];

  longint pcs[6], base[6], strd[6];
  longint stride_pick[7] = '{4, 8, 64, 255, 512, 0, -8};

  initial begin
    // Train, backpressure hold, no repeat issue, break and retrain
    tbl[0]  = '{1'b0, 1'b1, 39'h1000, 1'b1, 1'b0, 39'h0,    8'h00};
    tbl[1]  = '{1'b0, 1'b1, 39'h1040, 1'b1, 1'b0, 39'h0,    8'h00};
    tbl[2]  = '{1'b0, 1'b1, 39'h1080, 1'b1, 1'b0, 39'h0,    8'h00};
    tbl[3]  = '{1'b0, 1'b1, 39'h10C0, 1'b0, 1'b1, 39'h10C0, 8'h40};
    for (int i = 4; i <= 8; i++) tbl[i] = '{1'b0, 1'b0, 39'h0, 1'b0, 1'b1, 39'h10C0, 8'h40};
    tbl[9]  = '{1'b0, 1'b1, 39'h1100, 1'b1, 1'b0, 39'h10C0, 8'h40};
    tbl[10] = '{1'b0, 1'b1, 39'h1140, 1'b1, 1'b0, 39'h10C0, 8'h40};
    tbl[11] = '{1'b0, 1'b1, 39'h2000, 1'b1, 1'b0, 39'h10C0, 8'h40};
    tbl[12] = '{1'b0, 1'b1, 39'h2040, 1'b1, 1'b0, 39'h10C0, 8'h40};
    tbl[13] = '{1'b0, 1'b1, 39'h2080, 1'b1, 1'b0, 39'h10C0, 8'h40};
    tbl[14] = '{1'b0, 1'b1, 39'h20C0, 1'b1, 1'b1, 39'h20C0, 8'h40};
    tbl[15] = '{1'b0, 1'b0, 39'h0,    1'b1, 1'b0, 39'h20C0, 8'h40};

    #2;
    do_reset();
    for (int i = 0; i < 16; i++) begin
      cyc(tbl[i].fl, tbl[i].lv, PA, tbl[i].addr, tbl[i].rdy);
      chk($sformatf("vec%0d_v", i), 64'(v_o), 64'(tbl[i].ev));
      chk($sformatf("vec%0d_addr", i), 64'(eff_addr_o), 64'(tbl[i].eaddr));
      chk($sformatf("vec%0d_stride", i), 64'(stride_o), 64'(tbl[i].estride));
      if (tbl[i].ev) begin
        chk($sformatf("vec%0d_pc", i), 64'(pc_o), 64'(PA));
        chk($sformatf("vec%0d_lc", i), 64'(loop_counter_o), 64'd8);
      end
    end

    // Stride too wide, then zero stride: never triggers
    do_reset();
    for (int i = 0; i < 6; i++) begin
      ld(39'h80000200, 39'(64'h4000 + 64'(i) * 64'h200), 1'b1);
      chk("range_wide_v", 64'(v_o), 64'd0);
    end
    for (int i = 0; i < 6; i++) begin
      ld(39'h80000300, 39'h5000, 1'b1);
      chk("range_zero_v", 64'(v_o), 64'd0);
    end

    // Replacement: PC0 partly trained, evicted by the 5th PC, then retrains from scratch
    do_reset();
    ld(39'h80001000, 39'h100, 1'b1);
    ld(39'h80001000, 39'h110, 1'b1);
    ld(39'h80001000, 39'h120, 1'b1);
    chk("repl_pre_v", 64'(v_o), 64'd0);
    ld(39'h80001100, 39'h500, 1'b1);
    ld(39'h80001200, 39'h600, 1'b1);
    ld(39'h80001300, 39'h700, 1'b1);
    ld(39'h80001400, 39'h800, 1'b1);
    ld(39'h80001000, 39'h130, 1'b1); chk("repl_evicted_v", 64'(v_o), 64'd0);
    ld(39'h80001000, 39'h140, 1'b1); chk("repl_r1_v", 64'(v_o), 64'd0);
    ld(39'h80001000, 39'h150, 1'b0); chk("repl_r2_v", 64'(v_o), 64'd0);
    ld(39'h80001000, 39'h160, 1'b0); chk("repl_r3_v", 64'(v_o), 64'd1);
    chk("repl_addr", 64'(eff_addr_o), 64'h160);
    chk("repl_stride", 64'(stride_o), 64'h10);
    chk("repl_pc", 64'(pc_o), 64'h80001000);

    // Flush with pending descriptor and same-cycle load
    cyc(1'b1, 1'b1, 39'h80001000, 39'h170, 1'b0);
    chk("flush_pending_v", 64'(v_o), 64'd0);
    ld(39'h80003000, 39'h9000, 1'b1);
    ld(39'h80003000, 39'h9008, 1'b1);
    ld(39'h80003000, 39'h9010, 1'b1);
    cyc(1'b1, 1'b0, 39'h0, 39'h0, 1'b1);
    ld(39'h80003000, 39'h9018, 1'b1); chk("flush_tbl0_v", 64'(v_o), 64'd0);
    ld(39'h80003000, 39'h9020, 1'b1); chk("flush_tbl1_v", 64'(v_o), 64'd0);
    ld(39'h80003000, 39'h9028, 1'b0); chk("flush_tbl2_v", 64'(v_o), 64'd0);
    ld(39'h80003000, 39'h9030, 1'b0); chk("flush_tbl3_v", 64'(v_o), 64'd1);
    chk("flush_tbl_addr", 64'(eff_addr_o), 64'h9030);

    // Asynchronous reset mid-train with a descriptor pending
    ld(39'h80004000, 39'hA000, 1'b0);
    ld(39'h80004000, 39'hA004, 1'b0);
    ld(39'h80004000, 39'hA008, 1'b0);
    chk("hold_v", 64'(v_o), 64'd1);
    chk("hold_addr", 64'(eff_addr_o), 64'h9030);
    #2 reset_n_i = 1'b0;
    #1;
    chk("async_rst_v", 64'(v_o), 64'd0);
    chk("async_rst_addr", 64'(eff_addr_o), 64'd0);
    @(posedge clk_i); #1;
    reset_n_i = 1'b1;
    ld(39'h80004000, 39'hA00C, 1'b1); chk("rst_retrain0_v", 64'(v_o), 64'd0);
    ld(39'h80004000, 39'hA010, 1'b1); chk("rst_retrain1_v", 64'(v_o), 64'd0);
    ld(39'h80004000, 39'hA014, 1'b1); chk("rst_retrain2_v", 64'(v_o), 64'd0);
    ld(39'h80004000, 39'hA018, 1'b1); chk("rst_retrain3_v", 64'(v_o), 64'd1);
    chk("rst_retrain_stride", 64'(stride_o), 64'h4);

    // Randomized traffic against the reference model
    do_reset();
    model_reset();
    for (int k = 0; k < 6; k++) begin
      pcs[k]  = 64'h80002000 + 64'(k) * 64'h40;
      base[k] = 64'h10000 * 64'(k + 1);
      strd[k] = stride_pick[$urandom_range(0, 6)];
    end
    for (int n = 0; n < 2000; n++) begin
      bit fl, lv, rdy;
      int k;
      fl  = ($urandom_range(0, 99) < 2);
      lv  = ($urandom_range(0, 9) < 7);
      rdy = ($urandom_range(0, 9) < 6);
      k   = ($urandom_range(0, 19) == 0) ? $urandom_range(4, 5) : $urandom_range(0, 3);
      if ($urandom_range(0, 39) == 0) strd[k] = stride_pick[$urandom_range(0, 6)];
      if ($urandom_range(0, 63) == 0) base[k] = longint'($urandom);
      if (lv) base[k] = (base[k] + strd[k]) & longint'(MASK);
      cyc(fl, lv, 39'(pcs[k]), 39'(base[k]), rdy);
      model_step(fl, lv, pcs[k], base[k], rdy);
      chk("rnd_v", 64'(v_o), 64'(m_v));
      chk("rnd_pc", 64'(pc_o), 64'(m_pc));
      chk("rnd_addr", 64'(eff_addr_o), 64'(m_addr));
      chk("rnd_stride", 64'(stride_o), 64'(m_stride));
      chk("rnd_lc", 64'(loop_counter_o), 64'(m_lc));
    end

    load_v_i = 1'b0;
    flush_i  = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
